// File: rtl/tp_input_capture.sv
// Test-point input capture: synchronizes raw test-point legs, counts rising edges per
// channel and records a triggered snapshot of DEPTH words for software readback.
module tp_input_capture #(
    parameter int NCH   = 8,
    parameter int CNT_W = 16,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_B,
    input  logic [NCH-1:0]   TP_IN,
    input  logic [NCH-1:0]   TRIG_MASK,
    input  logic             ARM,
    input  logic             DISARM,
    input  logic             FORCE_TRIG,
    input  logic             CNT_CLR,
    input  logic [3:0]       CNT_SEL,
    output logic [CNT_W-1:0] CNT_DATA,
    input  logic [AW-1:0]    RD_ADDR,
    output logic [NCH-1:0]   RD_DATA,
    output logic [NCH-1:0]   LIVE,
    output logic [1:0]       STATE,
    output logic             DONE,
    output logic [AW:0]      WR_CNT
);

    // state   | meaning
    // IDLE    | waiting for ARM
    // ARMED   | waiting for a masked rising edge or FORCE_TRIG
    // CAPTURE | writing one synchronized sample per cycle
    // DONE    | buffer full, held until re-armed
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    state_t           state, state_nxt;
    logic [NCH-1:0]   s1, s2, s3;
    logic [NCH-1:0]   rise;
    logic             trig;
    logic [AW:0]      wr_cnt, wr_cnt_nxt;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [NCH-1:0]   mem [DEPTH];
    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] cnt_view [16];

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= TP_IN;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign LIVE = s2;
    assign trig = (|(rise & TRIG_MASK)) | FORCE_TRIG;

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (CNT_CLR)
                    cnt[i] <= '0;
                else if (rise[i] && (cnt[i] != {CNT_W{1'b1}}))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Pad the readout view to all 16 selector codes so unused codes read zero.
    for (genvar g = 0; g < 16; g++) begin : g_view
        if (g < NCH) begin : g_real
            assign cnt_view[g] = cnt[g];
        end else begin : g_zero
            assign cnt_view[g] = '0;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        mem_we     = 1'b0;
        mem_waddr  = wr_cnt[AW-1:0];
        if (DISARM) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ARM) begin
                        state_nxt  = ST_ARMED;
                        wr_cnt_nxt = '0;
                    end
                end
                ST_ARMED: begin
                    if (trig) begin
                        state_nxt  = ST_CAPTURE;
                        mem_we     = 1'b1;
                        mem_waddr  = '0;
                        wr_cnt_nxt = (AW + 1)'(1);
                    end
                end
                ST_CAPTURE: begin
                    mem_we     = 1'b1;
                    wr_cnt_nxt = wr_cnt + 1'b1;
                    if (wr_cnt_nxt == FULL) state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    if (ARM) begin
                        state_nxt  = ST_ARMED;
                        wr_cnt_nxt = '0;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            state    <= ST_IDLE;
            wr_cnt   <= '0;
            CNT_DATA <= '0;
            RD_DATA  <= '0;
        end else begin
            state    <= state_nxt;
            wr_cnt   <= wr_cnt_nxt;
            CNT_DATA <= cnt_view[CNT_SEL];
            RD_DATA  <= mem[RD_ADDR];
        end
    end

    // Snapshot RAM carries no reset so it can map onto block/distributed memory.
    always_ff @(posedge CLK) begin
        if (mem_we) mem[mem_waddr] <= s2;
    end

    assign STATE  = state;
    assign DONE   = (state == ST_DONE);
    assign WR_CNT = wr_cnt;

endmodule

// File: tb/tb_tp_input_capture.sv
// Bench for tp_input_capture: FSM vector table, directed capture/counter sequences and
// randomized counter/live checks against an input-history reference model.
module tb_tp_input_capture;

    localparam int JN = 25;

    logic        CLK, RST_B;
    logic [7:0]  tp_drv, tp_bus, TRIG_MASK;
    logic        jit, jit_go, jit_done;
    logic        ARM, DISARM, FORCE_TRIG, CNT_CLR;
    logic [3:0]  CNT_SEL, RD_ADDR;
    logic [15:0] cnt_data;
    logic [3:0]  cnt_data4;
    logic [7:0]  rd_data, rd_data4, live, live4;
    logic [1:0]  state, state4;
    logic        done, done4;
    logic [4:0]  wr_cnt, wr_cnt4;

    assign tp_bus = tp_drv | {3'b000, jit, 4'b0000};

    tp_input_capture #(.NCH(8), .CNT_W(16), .DEPTH(16)) dut (
        .CLK(CLK), .RST_B(RST_B), .TP_IN(tp_bus), .TRIG_MASK(TRIG_MASK), .ARM(ARM),
        .DISARM(DISARM), .FORCE_TRIG(FORCE_TRIG), .CNT_CLR(CNT_CLR), .CNT_SEL(CNT_SEL),
        .CNT_DATA(cnt_data), .RD_ADDR(RD_ADDR), .RD_DATA(rd_data), .LIVE(live),
        .STATE(state), .DONE(done), .WR_CNT(wr_cnt));

    tp_input_capture #(.NCH(8), .CNT_W(4), .DEPTH(16)) dut4 (
        .CLK(CLK), .RST_B(RST_B), .TP_IN(tp_bus), .TRIG_MASK(TRIG_MASK), .ARM(ARM),
        .DISARM(DISARM), .FORCE_TRIG(FORCE_TRIG), .CNT_CLR(CNT_CLR), .CNT_SEL(CNT_SEL),
        .CNT_DATA(cnt_data4), .RD_ADDR(RD_ADDR), .RD_DATA(rd_data4), .LIVE(live4),
        .STATE(state4), .DONE(done4), .WR_CNT(wr_cnt4));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Reference model: hist[n] is the pin value seen at clock edge n; the pin level is
    // visible on LIVE one edge later and a 0->1 step is counted two edges later.
    logic [7:0]  hist [0:65535];
    int          edge_n = 0;
    int          base = 0;
    int          mcnt [8];
    int          mcnt4 [8];
    logic [15:0] exp_cd;
    logic [3:0]  exp_cd4;

    function automatic logic [7:0] hv(input int m);
        if (m < base) return 8'h00;
        return hist[m];
    endfunction

    always @(posedge CLK or negedge RST_B) begin : model
        logic [7:0] r;
        if (!RST_B) begin
            for (int i = 0; i < 8; i++) begin
                mcnt[i]  = 0;
                mcnt4[i] = 0;
            end
            exp_cd  = '0;
            exp_cd4 = '0;
            base    = edge_n;
        end else begin
            hist[edge_n] = tp_bus;
            r = hv(edge_n - 2) & ~hv(edge_n - 3);
            exp_cd  = (CNT_SEL < 4'd8) ? 16'(mcnt[CNT_SEL[2:0]]) : 16'h0;
            exp_cd4 = (CNT_SEL < 4'd8) ? 4'(mcnt4[CNT_SEL[2:0]]) : 4'h0;
            for (int i = 0; i < 8; i++) begin
                if (CNT_CLR) begin
                    mcnt[i]  = 0;
                    mcnt4[i] = 0;
                end else if (r[i]) begin
                    if (mcnt[i] < 65535) mcnt[i]++;
                    if (mcnt4[i] < 15) mcnt4[i]++;
                end
            end
            edge_n++;
        end
    end

    initial begin
        jit      = 1'b0;
        jit_done = 1'b0;
        wait (jit_go);
        @(posedge CLK);
        #1;
        // even delays from an even start time never land on a (odd-time) rising edge
        for (int p = 0; p < JN; p++) begin
            jit = 1'b1;
            #(2 * $urandom_range(8, 12));
            jit = 1'b0;
            #(2 * $urandom_range(8, 12));
        end
        jit_done = 1'b1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse(input int ch, input int hi, input int lo);
        tp_drv[ch] = 1'b1;
        repeat (hi) tick();
        tp_drv[ch] = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic read_cnt(input logic [3:0] sel, input logic [15:0] e16, input logic [3:0] e4);
        CNT_SEL = sel;
        tick();
        chk($sformatf("cnt16 sel%0d", sel), 32'(cnt_data), 32'(e16));
        chk($sformatf("cnt4 sel%0d", sel), 32'(cnt_data4), 32'(e4));
    endtask

    task automatic clr_cnt();
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
    endtask

    typedef struct packed {
        logic       arm;
        logic       disarm;
        logic       frc;
        logic [7:0] mask;
        logic [7:0] tp;
        logic [1:0] st;
        logic [4:0] wr;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic d, input logic f, input logic [7:0] m,
                                input logic [7:0] t, input logic [1:0] s, input logic [4:0] w);
        vec_t v;
        v.arm = a; v.disarm = d; v.frc = f; v.mask = m; v.tp = t; v.st = s; v.wr = w;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int k;
        logic [7:0] w0;
        RST_B = 1'b1; tp_drv = '0; TRIG_MASK = '0; ARM = 0; DISARM = 0; FORCE_TRIG = 0;
        CNT_CLR = 0; CNT_SEL = '0; RD_ADDR = '0; jit_go = 1'b0;

        //          arm dis frc mask   tp     st wr
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'hFF, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 2, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 2, 2));
        tbl.push_back(mk(0, 0, 1, 8'h00, 8'h00, 2, 3));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 2, 4));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 2, 5));
        tbl.push_back(mk(0, 1, 0, 8'h00, 8'h00, 0, 5));
        tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 0, 5));
        tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h10, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h10, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h10, 2, 1));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h10, 2, 2));
        tbl.push_back(mk(0, 1, 0, 8'h10, 8'h10, 0, 2));
        tbl.push_back(mk(1, 0, 0, 8'h10, 8'h10, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h10, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h10, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h10, 8'h10, 2, 1));
        tbl.push_back(mk(0, 0, 0, 8'h10, 8'h10, 2, 2));
        tbl.push_back(mk(0, 1, 0, 8'h10, 8'h10, 0, 2));

        // power-on reset
        #1 RST_B = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("por state", 32'(state), 0);
        chk("por done", 32'(done), 0);
        chk("por wr_cnt", 32'(wr_cnt), 0);
        chk("por live", 32'(live), 0);
        chk("por cnt_data", 32'(cnt_data), 0);
        chk("por rd_data", 32'(rd_data), 0);
        RST_B = 1'b1;
        tick();

        // FSM control vectors
        for (int r = 0; r < tbl.size(); r++) begin
            ARM = tbl[r].arm; DISARM = tbl[r].disarm; FORCE_TRIG = tbl[r].frc;
            TRIG_MASK = tbl[r].mask; tp_drv = tbl[r].tp;
            tick();
            chk($sformatf("tbl%0d state", r), 32'(state), 32'(tbl[r].st));
            chk($sformatf("tbl%0d wr_cnt", r), 32'(wr_cnt), 32'(tbl[r].wr));
            chk($sformatf("tbl%0d done", r), 32'(done), 32'(tbl[r].st == 2'd3));
        end
        ARM = 0; DISARM = 0; FORCE_TRIG = 0; tp_drv = '0;

        // masked trigger capture on ch0 with activity on the other channels
        TRIG_MASK = 8'h01;
        repeat (3) tick();
        ARM = 1; tick(); ARM = 0;
        chk("cap armed", 32'(state), 1);
        for (int w = 0; w < 7; w++) begin
            tp_drv = 8'h02 << w;
            tick();
            chk($sformatf("cap walk%0d state", w), 32'(state), 1);
        end
        tp_drv = 8'($urandom) | 8'h01;
        tick();
        k = edge_n - 1;
        chk("cap edge k state", 32'(state), 1);
        for (int c = 1; c <= 17; c++) begin
            tp_drv = 8'($urandom) | 8'h01;
            tick();
            chk($sformatf("cap k+%0d state", c), 32'(state), (c < 2) ? 1 : (c < 17) ? 2 : 3);
            chk($sformatf("cap k+%0d wr_cnt", c), 32'(wr_cnt), (c < 2) ? 0 : c - 1);
            chk($sformatf("cap k+%0d done", c), 32'(done), (c == 17) ? 1 : 0);
        end
        repeat (3) tick();
        chk("cap hold state", 32'(state), 3);
        chk("cap hold wr_cnt", 32'(wr_cnt), 16);
        for (int j = 0; j < 16; j++) begin
            RD_ADDR = 4'(j);
            tick();
            chk($sformatf("cap word%0d", j), 32'(rd_data), 32'(hv(k + j)));
            if (j == 0) w0 = rd_data;
        end
        chk("cap word0 ch0", 32'(w0[0]), 1);
        ARM = 1; tick(); ARM = 0;
        chk("rearm state", 32'(state), 1);
        chk("rearm done", 32'(done), 0);
        chk("rearm wr_cnt", 32'(wr_cnt), 0);
        DISARM = 1; tick(); DISARM = 0;
        chk("disarm armed", 32'(state), 0);
        TRIG_MASK = '0; tp_drv = '0;

        // edge counting: 5 pulses on ch2
        repeat (3) tick();
        clr_cnt();
        repeat (5) pulse(2, 3, 3);
        repeat (2) tick();
        for (int s = 0; s < 8; s++) read_cnt(4'(s), (s == 2) ? 16'd5 : 16'd0, (s == 2) ? 4'd5 : 4'd0);
        read_cnt(4'd12, 16'd0, 4'd0);

        // saturation: 20 pulses on ch5
        clr_cnt();
        repeat (20) pulse(5, 3, 3);
        repeat (2) tick();
        read_cnt(4'd5, 16'd20, 4'd15);
        read_cnt(4'd9, 16'd0, 4'd0);

        // clear coincident with a rise
        clr_cnt();
        pulse(1, 3, 3);
        read_cnt(4'd1, 16'd1, 4'd1);
        tp_drv[1] = 1'b1;
        tick();
        tick();
        CNT_CLR = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        tp_drv[1] = 1'b0;
        repeat (3) tick();
        read_cnt(4'd1, 16'd0, 4'd0);

        // minimum-width pulse
        clr_cnt();
        pulse(3, 2, 3);
        read_cnt(4'd3, 16'd1, 4'd1);

        // asynchronous jittered input on ch4 at about CLK/4
        clr_cnt();
        jit_go = 1'b1;
        for (int t = 0; t < 3000 && !jit_done; t++) tick();
        chk("jitter finished", 32'(jit_done), 1);
        repeat (3) tick();
        read_cnt(4'd4, 16'(JN), 4'd15);

        // randomized pins, clears and selects against the model
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 1) == 0) tp_drv = 8'($urandom);
            CNT_CLR = ($urandom_range(0, 39) == 0);
            CNT_SEL = 4'($urandom_range(0, 15));
            tick();
            chk($sformatf("rnd%0d cnt16", n), 32'(cnt_data), 32'(exp_cd));
            chk($sformatf("rnd%0d cnt4", n), 32'(cnt_data4), 32'(exp_cd4));
            chk($sformatf("rnd%0d live", n), 32'(live), 32'(hv(edge_n - 2)));
        end
        CNT_CLR = 1'b0;

        // reset asserted in the middle of a capture
        tp_drv = 8'hFF;
        repeat (3) tick();
        chk("pre-rst live", 32'(live), 32'hFF);
        ARM = 1; tick(); ARM = 0;
        FORCE_TRIG = 1; tick(); FORCE_TRIG = 0;
        tick();
        tick();
        chk("pre-rst state", 32'(state), 2);
        chk("pre-rst wr_cnt", 32'(wr_cnt), 3);
        RST_B = 1'b0;
        #2;
        chk("rst state", 32'(state), 0);
        chk("rst done", 32'(done), 0);
        chk("rst wr_cnt", 32'(wr_cnt), 0);
        chk("rst live", 32'(live), 0);
        chk("rst rd_data", 32'(rd_data), 0);
        for (int s = 0; s < 16; s++) read_cnt(4'(s), 16'd0, 4'd0);
        tp_drv = '0;
        RST_B = 1'b1;
        repeat (3) tick();
        chk("post-rst state", 32'(state), 0);
        for (int s = 0; s < 8; s++) read_cnt(4'(s), 16'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
